// File: rtl/mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit
//
// MIPS instruction-fetch stage. It holds the program counter, reads one word
// from a synchronous instruction memory, pushes {PC+4, instruction} to decode
// over a 4-phase bundled-data channel (f2d), then pulls a 33-bit redirect word
// back from decode over a second 4-phase channel (d2f). It then updates the PC
// and starts the next fetch.
//
// Ports:
//   IM_CLK   in   1   clock, shared with the instruction memory
//   Z_R      in   1   asynchronous active-high reset
//   IM_ADDR  out  32  instruction memory word address = {2'b00, PC[31:2]}
//   IM_DATA  in   32  instruction word, valid one edge after IM_ADDR
//   f2d_R    out  1   f2d request (fetch pushes)
//   f2d      out  64  [63:32] = PC+4, [31:0] = instruction
//   f2d_A    in   1   f2d acknowledge
//   d2f_R    out  1   d2f request (fetch pulls)
//   d2f      in   33  [32] = redirect taken, [31:0] = target address
//   d2f_A    in   1   d2f acknowledge, d2f data valid while high
//
// Parameters:
//   RESET_PC  PC loaded on reset (word aligned)
//
// Optional feature macro: FETCH_ALIGN_EN
//   When defined, the redirect target has bits [1:0] cleared before it is
//   loaded into the PC. When undefined, the target is loaded verbatim.
// ---------------------------------------------------------------------------
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        IM_CLK,
    input  logic        Z_R,
    output logic [31:0] IM_ADDR,
    input  logic [31:0] IM_DATA,
    output logic        f2d_R,
    output logic [63:0] f2d,
    input  logic        f2d_A,
    output logic        d2f_R,
    input  logic [32:0] d2f,
    input  logic        d2f_A
);

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        WAIT_MEM = 3'd1,
        PUSH     = 3'd2,
        PUSH_RTZ = 3'd3,
        PULL     = 3'd4,
        PULL_RTZ = 3'd5
    } fetchState_t;

    fetchState_t state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] f2dPc_q, f2dPc_d;
    logic        f2dReq_q, f2dReq_d;
    logic        d2fReq_q, d2fReq_d;
    logic [32:0] redirect_q, redirect_d;

    logic [31:0] pcPlus4;
    logic [31:0] redirectTarget;

    // PC+4 wraps modulo 2^32, so the top word of the address space falls
    // through to address zero.
    assign pcPlus4 = pc_q + 32'd4;

`ifdef FETCH_ALIGN_EN
    // Force the redirect onto a word boundary so every PC is aligned.
    assign redirectTarget = redirect_q[31:0] & 32'hFFFF_FFFC;
`else
    // Target taken verbatim; IM_ADDR still ignores PC[1:0].
    assign redirectTarget = redirect_q[31:0];
`endif

    // All outputs come straight from registers. The f2d payload is built from
    // two registers that only load in WAIT_MEM, so it stays frozen through the
    // whole push handshake.
    assign IM_ADDR = {2'b00, pc_q[31:2]};
    assign f2d     = {f2dPc_q, instr_q};
    assign f2d_R   = f2dReq_q;
    assign d2f_R   = d2fReq_q;

    // State register. Reset may arrive mid-handshake; both requests drop at
    // once and the machine restarts a fresh fetch from RESET_PC.
    always_ff @(posedge IM_CLK or posedge Z_R) begin
        if (Z_R) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            f2dPc_q    <= 32'd0;
            f2dReq_q   <= 1'b0;
            d2fReq_q   <= 1'b0;
            redirect_q <= 33'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            f2dPc_q    <= f2dPc_d;
            f2dReq_q   <= f2dReq_d;
            d2fReq_q   <= d2fReq_d;
            redirect_q <= redirect_d;
        end
    end

    // Next-state logic. The push must fully return to zero before the pull
    // starts, which keeps the two requests mutually exclusive. The PC moves
    // only after the pull's acknowledge has returned to zero.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        f2dPc_d    = f2dPc_q;
        f2dReq_d   = f2dReq_q;
        d2fReq_d   = d2fReq_q;
        redirect_d = redirect_q;

        case (state_q)
            FETCH: begin
                state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                instr_d  = IM_DATA;
                f2dPc_d  = pcPlus4;
                f2dReq_d = 1'b1;
                state_d  = PUSH;
            end
            PUSH: begin
                if (f2d_A) begin
                    f2dReq_d = 1'b0;
                    state_d  = PUSH_RTZ;
                end
            end
            PUSH_RTZ: begin
                if (!f2d_A) begin
                    d2fReq_d = 1'b1;
                    state_d  = PULL;
                end
            end
            PULL: begin
                if (d2f_A) begin
                    redirect_d = d2f;
                    d2fReq_d   = 1'b0;
                    state_d    = PULL_RTZ;
                end
            end
            PULL_RTZ: begin
                if (!d2f_A) begin
                    pc_d    = redirect_q[32] ? redirectTarget : pcPlus4;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_unit
//
// Directed bench for mips_fetch_unit. Two instances are built: one with the
// default RESET_PC and one starting at 32'hFFFF_FFFC to exercise the PC+4
// wrap. A select signal routes the handshake stimulus to one instance at a
// time; the idle instance is held in reset or parked waiting for an ack.
// Both share one synchronous instruction memory model.
// ---------------------------------------------------------------------------
module tb_mips_fetch_unit;

    logic        IM_CLK;
    logic        zR;
    logic        wZR;
    logic        sel;
    logic        f2dA;
    logic        d2fA;
    logic [32:0] d2fData;

    logic [31:0] imAddr,  wImAddr;
    logic [31:0] imData,  wImData;
    logic        f2dR,    wF2dR;
    logic [63:0] f2dOut,  wF2dOut;
    logic        d2fR,    wD2fR;

    logic [31:0] mem [0:255];

    int passCount;
    int totalCount;

    logic [63:0] seenF2d;
    logic [31:0] seenAddr;

    // Requests, payload and address of whichever instance is under test.
    wire        curF2dR  = sel ? wF2dR   : f2dR;
    wire        curD2fR  = sel ? wD2fR   : d2fR;
    wire [63:0] curF2d   = sel ? wF2dOut : f2dOut;
    wire [31:0] curAddr  = sel ? wImAddr : imAddr;

    wire        dutF2dA  = sel ? 1'b0 : f2dA;
    wire        dutD2fA  = sel ? 1'b0 : d2fA;
    wire        wrapF2dA = sel ? f2dA : 1'b0;
    wire        wrapD2fA = sel ? d2fA : 1'b0;

    mips_fetch_unit dut (
        .IM_CLK  (IM_CLK),
        .Z_R     (zR),
        .IM_ADDR (imAddr),
        .IM_DATA (imData),
        .f2d_R   (f2dR),
        .f2d     (f2dOut),
        .f2d_A   (dutF2dA),
        .d2f_R   (d2fR),
        .d2f     (d2fData),
        .d2f_A   (dutD2fA)
    );

    mips_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .IM_CLK  (IM_CLK),
        .Z_R     (wZR),
        .IM_ADDR (wImAddr),
        .IM_DATA (wImData),
        .f2d_R   (wF2dR),
        .f2d     (wF2dOut),
        .f2d_A   (wrapF2dA),
        .d2f_R   (wD2fR),
        .d2f     (d2fData),
        .d2f_A   (wrapD2fA)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        IM_CLK = 1'b0;
        forever #5 IM_CLK = ~IM_CLK;
    end

    // Synchronous instruction memory: data valid one edge after the address.
    always @(posedge IM_CLK) begin
        imData  <= mem[imAddr[7:0]];
        wImData <= mem[wImAddr[7:0]];
    end

    // One comparison: count it, and report tag, observed and expected on
    // a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Wait on negedges until the selected request reaches a level, bounded.
    task automatic waitReq(input bit isD2f, input logic lvl, input string tag);
        int n;
        n = 0;
        while (((isD2f ? curD2fR : curF2dR) !== lvl) && (n < 50)) begin
            @(negedge IM_CLK);
            n++;
        end
        checkOutput(tag, {63'd0, ((isD2f ? curD2fR : curF2dR) === lvl)}, 64'd1);
    endtask

    // One full fetch transaction as seen by decode: take the push (optionally
    // stalling the ack), then answer the pull with the given redirect word.
    task automatic applyStimulus(input logic [32:0] redir, input int stall,
                                 output logic [63:0] f2dSeen,
                                 output logic [31:0] addrSeen);
        waitReq(1'b0, 1'b1, "f2dReqRise");
        f2dSeen  = curF2d;
        addrSeen = curAddr;
        for (int i = 0; i < stall; i++) begin
            @(negedge IM_CLK);
            checkOutput("stallF2dReq",  {63'd0, curF2dR}, 64'd1);
            checkOutput("stallF2dHeld", curF2d, f2dSeen);
            checkOutput("stallD2fReq",  {63'd0, curD2fR}, 64'd0);
        end
        f2dA = 1'b1;
        @(negedge IM_CLK);
        waitReq(1'b0, 1'b0, "f2dReqFall");
        if (stall > 0) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge IM_CLK);
                checkOutput("ackHighD2fReq",  {63'd0, curD2fR}, 64'd0);
                checkOutput("ackHighF2dHeld", curF2d, f2dSeen);
            end
        end
        f2dA = 1'b0;
        @(negedge IM_CLK);
        waitReq(1'b1, 1'b1, "d2fReqRise");
        d2fData = redir;
        d2fA    = 1'b1;
        @(negedge IM_CLK);
        waitReq(1'b1, 1'b0, "d2fReqFall");
        d2fA    = 1'b0;
        d2fData = 33'd0;
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        sel        = 1'b0;
        f2dA       = 1'b0;
        d2fA       = 1'b0;
        d2fData    = 33'd0;
        zR         = 1'b1;
        wZR        = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0]   = 32'h2001_0005;
        mem[1]   = 32'h2002_0007;
        mem[16]  = 32'h8C10_0010;
        mem[17]  = 32'hAC11_0011;
        mem[255] = 32'h3C0F_FFFF;

        // Reset state.
        #1;
        checkOutput("rstF2dReq", {63'd0, f2dR}, 64'd0);
        checkOutput("rstD2fReq", {63'd0, d2fR}, 64'd0);
        checkOutput("rstF2d",    f2dOut, 64'd0);
        checkOutput("rstImAddr", {32'd0, imAddr}, 64'd0);
        @(negedge IM_CLK);
        @(negedge IM_CLK);
        zR = 1'b0;

        // Two sequential fetches, the second answered with a redirect to 0x40.
        applyStimulus(33'd0, 0, seenF2d, seenAddr);
        checkOutput("seq1F2d",  seenF2d, {32'h4, 32'h2001_0005});
        checkOutput("seq1Addr", {32'd0, seenAddr}, 64'd0);
        applyStimulus({1'b1, 32'h0000_0040}, 0, seenF2d, seenAddr);
        checkOutput("seq2F2d",  seenF2d, {32'h8, 32'h2002_0007});
        checkOutput("seq2Addr", {32'd0, seenAddr}, 64'd1);

        // Redirect target fetched, with a 5-cycle ack stall on the push.
        applyStimulus(33'd0, 5, seenF2d, seenAddr);
        checkOutput("redirF2d",  seenF2d, {32'h44, 32'h8C10_0010});
        checkOutput("redirAddr", {32'd0, seenAddr}, 64'd16);

        // Sequential after the redirect, then redirect to unaligned 0x43.
        applyStimulus({1'b1, 32'h0000_0043}, 0, seenF2d, seenAddr);
        checkOutput("postRedirF2d",  seenF2d, {32'h48, 32'hAC11_0011});
        checkOutput("postRedirAddr", {32'd0, seenAddr}, 64'd17);

        applyStimulus(33'd0, 0, seenF2d, seenAddr);
`ifdef FETCH_ALIGN_EN
        checkOutput("unalignF2d", seenF2d, {32'h44, 32'h8C10_0010});
`else
        checkOutput("unalignF2d", seenF2d, {32'h47, 32'h8C10_0010});
`endif
        checkOutput("unalignAddr", {32'd0, seenAddr}, 64'd16);

        // Reset asserted while the pull request is high.
        waitReq(1'b0, 1'b1, "midF2dReqRise");
        f2dA = 1'b1;
        @(negedge IM_CLK);
        waitReq(1'b0, 1'b0, "midF2dReqFall");
        f2dA = 1'b0;
        @(negedge IM_CLK);
        waitReq(1'b1, 1'b1, "midD2fReqRise");
        zR = 1'b1;
        #1;
        checkOutput("midRstD2fReq", {63'd0, d2fR}, 64'd0);
        checkOutput("midRstF2dReq", {63'd0, f2dR}, 64'd0);
        checkOutput("midRstImAddr", {32'd0, imAddr}, 64'd0);
        checkOutput("midRstF2d",    f2dOut, 64'd0);
        @(negedge IM_CLK);
        zR = 1'b0;
        applyStimulus(33'd0, 0, seenF2d, seenAddr);
        checkOutput("afterRstF2d",  seenF2d, {32'h4, 32'h2001_0005});
        checkOutput("afterRstAddr", {32'd0, seenAddr}, 64'd0);

        // PC wrap on the second instance, starting at 32'hFFFF_FFFC.
        sel = 1'b1;
        @(negedge IM_CLK);
        wZR = 1'b0;
        applyStimulus(33'd0, 0, seenF2d, seenAddr);
        checkOutput("wrapF2d",  seenF2d, {32'h0, 32'h3C0F_FFFF});
        checkOutput("wrapAddr", {32'd0, seenAddr}, 64'h3FFF_FFFF);
        applyStimulus(33'd0, 0, seenF2d, seenAddr);
        checkOutput("wrapNextF2d",  seenF2d, {32'h4, 32'h2001_0005});
        checkOutput("wrapNextAddr", {32'd0, seenAddr}, 64'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
